// File: rtl/rr_mux_select.sv
// rr_mux_select: round-robin select sequencer for the 4-to-1 mux datapath.
// Grants one requesting channel at a time, keeps the grant for at least MIN_HOLD
// cycles, then rotates the search start past the channel that just finished.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   req    per-channel level request, bit i = channel i wants the mux
//   ack    downstream consumed the mux output this cycle
//   sel    registered mux select, index of the granted channel
//   grant  one-hot of the granted channel, all zero when not valid
//   valid  sel/grant are live
//   abort  one-cycle pulse: grant withdrawn because req[sel] dropped
module rr_mux_select #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned MIN_HOLD = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      ack,
  output logic [$clog2(NUM_CH)-1:0] sel,
  output logic [NUM_CH-1:0]         grant,
  output logic                      valid,
  output logic                      abort
);

  localparam int unsigned SelW = $clog2(NUM_CH);
  localparam int unsigned CntW = $clog2(MIN_HOLD + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MIN_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              state_q, state_d;
  logic [SelW-1:0]     ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic                valid_q, valid_d;
  logic                abort_q, abort_d;

  // Returns {found, index}: first set bit of r searching upward from start, wrapping.
  function automatic logic [SelW:0] pick(input logic [NUM_CH-1:0] r,
                                         input logic [SelW-1:0] start);
    logic [SelW-1:0] idx;
    pick = '0;
    // Walk from the far end so the closest candidate to start is written last.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = start + SelW'(i);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  logic [SelW:0]   arb_idle, arb_next;
  logic [SelW-1:0] sel_inc;
  logic            accept, rel_now;

  always_comb begin
    sel_inc  = sel_q + SelW'(1);
    arb_idle = pick(req, ptr_q);
    // Re-arbitration after a release never hands the same channel back immediately.
    arb_next = pick(req & ~(NUM_CH'(1) << sel_q), sel_inc);
    accept   = ack && (cnt_q == CntMax);
    rel_now  = accept || !req[sel_q];

    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    abort_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (arb_idle[SelW]) begin
          state_d = StGrant;
          sel_d   = arb_idle[SelW-1:0];
        end
      end
      StGrant: begin
        if (rel_now) begin
          ptr_d   = sel_inc;
          // A drop coinciding with an accepted ack is a normal completion.
          abort_d = !accept;
          cnt_d   = '0;
          if (arb_next[SelW]) begin
            sel_d = arb_next[SelW-1:0];
          end else begin
            state_d = StIdle;
          end
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    valid_d = (state_d == StGrant);
    grant_d = valid_d ? (NUM_CH'(1) << sel_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign valid = valid_q;
  assign abort = abort_q;

endmodule

// File: tb/tb_rr_mux_select.sv
// Scoreboard bench for rr_mux_select: two instances (MIN_HOLD=1 and MIN_HOLD=3).
// Stimulus pushes hand-computed expected outputs tagged with their cycle; a
// negedge monitor per instance pops and compares whenever valid or abort is high.
module tb_rr_mux_select;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       abort;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req1, req3;
  logic       ack1, ack3;
  logic [1:0] sel1, sel3;
  logic [3:0] grant1, grant3;
  logic       valid1, valid3, abort1, abort3;

  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[2][$];

  rr_mux_select #(.NUM_CH(4), .MIN_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .ack(ack1),
    .sel(sel1), .grant(grant1), .valid(valid1), .abort(abort1)
  );

  rr_mux_select #(.NUM_CH(4), .MIN_HOLD(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .ack(ack3),
    .sel(sel3), .grant(grant3), .valid(valid3), .abort(abort3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cycle, act, exp);
    end
  endtask

  task automatic mon(input int w, input logic [1:0] s, input logic [3:0] g,
                     input logic v, input logic ab);
    exp_t e;
    if (v || ab) begin
      while (q[w].size() > 0 && q[w][0].cyc < cycle) begin
        e = q[w].pop_front();
        checks++;
        errors++;
        $display("FAIL dut%0d missed output: got none at cycle %0d, expected sel=%0d valid=%0d abort=%0d",
                 w, e.cyc, e.sel, e.valid, e.abort);
      end
      if (q[w].size() == 0 || q[w][0].cyc != cycle) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected output at cycle %0d: got sel=%0d valid=%0d abort=%0d, required none",
                 w, cycle, s, v, ab);
      end else begin
        e = q[w].pop_front();
        chk($sformatf("dut%0d sel", w), int'(s), int'(e.sel));
        chk($sformatf("dut%0d grant", w), int'(g), int'(e.grant));
        chk($sformatf("dut%0d valid", w), int'(v), int'(e.valid));
        chk($sformatf("dut%0d abort", w), int'(ab), int'(e.abort));
      end
    end
  endtask

  always @(negedge clk) mon(0, sel1, grant1, valid1, abort1);
  always @(negedge clk) mon(1, sel3, grant3, valid3, abort3);

  // Drive one cycle of inputs to instance w and record what it must show after the edge.
  task automatic step(input int w, input logic [3:0] r, input logic a,
                      input logic ev, input logic [1:0] es, input logic eab);
    exp_t e;
    if (w == 0) begin
      req1 = r;
      ack1 = a;
    end else begin
      req3 = r;
      ack3 = a;
    end
    @(posedge clk);
    #1;
    if (ev || eab) begin
      e.cyc   = cycle;
      e.sel   = es;
      e.grant = ev ? (4'(1) << es) : 4'(0);
      e.valid = ev;
      e.abort = eab;
      q[w].push_back(e);
    end
  endtask

  task automatic chk_idle(input string name, input logic [1:0] s, input logic [3:0] g,
                          input logic v, input logic ab);
    chk({name, " sel"}, int'(s), 0);
    chk({name, " grant"}, int'(g), 0);
    chk({name, " valid"}, int'(v), 0);
    chk({name, " abort"}, int'(ab), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle("reset dut1", sel1, grant1, valid1, abort1);
    chk_idle("reset dut3", sel3, grant3, valid3, abort3);
  endtask

  initial begin
    req1 = '0;
    ack1 = 1'b0;
    req3 = '0;
    ack3 = 1'b0;
    do_reset();

    // Single request: one-cycle latency, ack releases to idle.
    step(0, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    step(0, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0);
    step(0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // All requesting with ack every cycle: rotation with no bubble.
    do_reset();
    step(0, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);
    step(0, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b0);
    step(0, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0);
    step(0, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b0);
    step(0, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);
    // Ack and drop together on ch0: completion, no abort, ptr -> 1.
    step(0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);

    // Abort: ch1 granted, held, then req dropped without ack.
    step(0, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    step(0, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    step(0, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b1);
    // ptr=2 so ch3 wins over ch0.
    step(0, 4'b1001, 1'b0, 1'b1, 2'd3, 1'b0);

    // Ack with req[3] dropping: no abort, ptr wraps to 0, ch0 back-to-back.
    step(0, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
    step(0, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    step(0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // MIN_HOLD=3: early acks ignored, release after the third valid cycle.
    step(1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
    step(1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
    step(1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
    step(1, 4'b0010, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset mid-grant on ch3 (ptr=1 here, so 1,2 empty, 3 wins).
    step(0, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle("midgrant reset dut1", sel1, grant1, valid1, abort1);
    // ptr back to 0: ch0 first; then drop gives exactly one abort cycle.
    step(0, 4'b1001, 1'b0, 1'b1, 2'd0, 1'b0);
    step(0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    step(0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    step(0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      while (q[w].size() > 0) begin
        exp_t e;
        e = q[w].pop_front();
        checks++;
        errors++;
        $display("FAIL dut%0d missed output: got none at cycle %0d, expected sel=%0d valid=%0d abort=%0d",
                 w, e.cyc, e.sel, e.valid, e.abort);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
